// File: rtl/store_size_rmw_if.sv
// Request and memory-port bundle for the SW/SH/SB store path.
// The control unit and memory sit on the master side; store_size_rmw is the slave.
interface store_size_rmw_if;
  logic        start;
  logic [1:0]  st_type;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, st_type, addr, data_in, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, err
  );

  modport slave (
    input  start, st_type, addr, data_in, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, err
  );
endinterface

// File: rtl/store_size_rmw.sv
// Store path for the multicycle MIPS datapath: SW is written directly.
// SH and SB read the containing word, merge the lane, then write the word back.
module store_size_rmw #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  store_size_rmw_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  localparam logic [1:0] TySw = 2'b00;
  localparam logic [1:0] TySh = 2'b01;
  localparam logic [1:0] TySb = 2'b10;
  localparam logic [1:0] TyIl = 2'b11;
  localparam logic [2:0] LatLast = 3'(MEM_LAT);

  state_e      state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        illegal;
  logic [31:0] merged;

  assign illegal = (bus.st_type == TyIl) ||
                   (bus.st_type == TySw && bus.addr[1:0] != 2'b00) ||
                   (bus.st_type == TySh && bus.addr[0]);

  // Lane merge over the word returned by the read; only used in the last READ cycle.
  always_comb begin
    merged = bus.mem_rdata;
    if (type_q == TySb) begin
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
    end else begin
      merged[{lane_q[1], 4'b0000} +: 16] = data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    lane_d  = lane_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          type_d = bus.st_type;
          lane_d = bus.addr[1:0];
          data_d = bus.data_in[15:0];
          addr_d = {bus.addr[31:2], 2'b00};
          if (illegal) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (bus.st_type == TySw) begin
            wdata_d = bus.data_in;
            state_d = StWrite;
          end else begin
            cnt_d   = '0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LatLast) begin
          wdata_d = merged;
          state_d = StWrite;
        end
      end
      StWrite: state_d = StDone;
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      type_q  <= TySw;
      lane_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decoded from the state register, so an async reset drops them at once.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wr    = (state_q == StWrite);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.err       = err_q;

endmodule
